eth_tx_fcs_ctrl: RTL and testbench
==================================

Name: eth_tx_fcs_ctrl

Overview:
- Transmit-side frame sequencer that sits between the MAC TX byte stream and the PHY/GMII serializer.
- Owns one instance of the team's crc32 byte engine (ports clk, rst active-high, valid, data, crc; 1-cycle latency; crc output stable while valid is low). It resets the engine per frame, feeds it every payload byte, pads short frames, appends the 4-byte FCS and enforces the inter-frame gap.
- Output is a valid/ready byte stream carrying the complete frame including FCS.

Parameters:
- MIN_FRAME, 60, minimum byte count before FCS (payload plus pad); range 1..1023.
- IFG_CYCLES, 12, idle cycles forced after the last FCS byte; 0 means no gap.
- PAD_BYTE, 8'h00, value of inserted pad bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input frame byte (destination MAC first, no FCS).
- s_last  in  1  marks the final input byte of the frame.
- s_ready  out  1  input byte accepted when s_valid && s_ready.
- m_valid  out  1  output byte valid.
- m_data  out  8  output byte.
- m_last  out  1  marks the final FCS byte.
- m_ready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on acceptance of the last FCS byte.
- pad_count  out  10  number of pad bytes inserted in the most recent frame; holds until the next frame_done.

Behaviour:
- Reset (rst_n=0 at a clk edge): state goes to IDLE; s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, frame_done=0, pad_count=0; byte counter cleared.
- The engine rst input is driven by !rst_n || state==IDLE. The engine therefore holds 32'hFFFFFFFF seed whenever the block is idle.
- Reset mid-frame abandons the frame immediately. No partial FCS is emitted and the next frame starts clean.
- IDLE:
  - s_ready=0, m_valid=0.
  - Go to DATA when s_valid=1. This costs one bubble cycle per frame.
- DATA:
  - Pass-through: m_valid=s_valid, m_data=s_data, s_ready=m_ready, m_last=0.
  - Engine valid = s_valid && m_ready, engine data = s_data.
  - The byte counter (10 bits, saturates at 1023) increments on each accepted byte.
  - On acceptance of the byte with s_last=1:
    - go to PAD if (count+1) < MIN_FRAME and padding is compiled in;
    - otherwise go to FCS.
- PAD:
  - s_ready=0, m_valid=1, m_data=PAD_BYTE.
  - Engine valid = m_ready.
  - Count increments per accepted pad byte. Go to FCS on the accept that makes count == MIN_FRAME.
  - pad_count records MIN_FRAME minus the payload length.
- FCS:
  - s_ready=0, m_valid=1. Engine valid=0, so the engine crc output stays stable.
  - A 2-bit index k advances 0..3 on each accepted byte; m_data = crc[31-8k -: 8]. This sends ~CRC state least-significant byte first, per IEEE 802.3.
  - m_last=1 when k==3. The first FCS byte may be presented the cycle after the last data/pad byte is accepted (engine latency is 1).
  - On acceptance of k==3: pulse frame_done, then go to IFG (or to IDLE if IFG_CYCLES==0).
- IFG:
  - s_ready=0, m_valid=0.
  - Counter runs IFG_CYCLES cycles, then goes to IDLE.
- Backpressure: m_valid, m_data and m_last hold unchanged while m_valid && !m_ready in PAD and FCS. In DATA they track the source, which holds per the valid/ready rule.
- Frames longer than 1023 bytes: the counter saturates, which only affects the padding decision. FCS is unaffected.
- Single-byte frame (s_last on the first byte) is legal and gets padded to MIN_FRAME.

Optional Feature:
- Macro ETH_TX_FCS_PAD_EN.
- Defined: short frames are padded as above.
- Undefined:
  - the PAD state and pad logic are not built;
  - DATA always goes to FCS after s_last;
  - pad_count is tied to 0.

Test Plan:
- ASCII "123456789" with MIN_FRAME=1 -> output is the 9 bytes, then 26 39 F4 CB with m_last on CB, and frame_done pulses once.
- 14-byte frame, padding enabled, MIN_FRAME=60 -> 46 bytes of 00 after the payload, FCS matches the software CRC-32 of the 60 bytes, pad_count=46, total 64 output bytes.
- Same 14-byte frame with ETH_TX_FCS_PAD_EN undefined -> 14 bytes plus FCS (18 total), pad_count=0.
- Random m_ready (~50% duty) on a 100-byte frame -> byte sequence identical to the m_ready=1 case, and output is stable during every stall.
- Two back-to-back frames with IFG_CYCLES=12 -> exactly 12 cycles of s_ready=0/m_valid=0 after the first frame_done, plus one IDLE bubble; the second FCS is correct, proving the engine re-seeded.
- rst_n low for one cycle mid-PAD -> all outputs return to reset values next cycle; the following frame "123456789" still yields 26 39 F4 CB.

Source files
------------

// File: rtl/eth_tx_fcs_ctrl.sv
// eth_tx_fcs_ctrl: TX frame sequencer - payload pass-through, optional short-frame pad, FCS append, IFG.
// Padding is built only when ETH_TX_FCS_PAD_EN is defined; otherwise pad_count is tied to 0.

module crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    logic [31:0] r_state;
    logic [31:0] w_next;

    always_comb begin
        w_next = r_state;
        for (int unsigned i = 0; i < 8; i++) begin
            w_next = {1'b0, w_next[31:1]} ^ ((w_next[0] ^ data[i]) ? 32'hEDB8_8320 : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '1;
        end else if (valid) begin
            r_state <= w_next;
        end
    end

    // Complemented and byte-swapped so crc[31:24] is the first FCS byte on the wire.
    assign crc = ~{r_state[7:0], r_state[15:8], r_state[23:16], r_state[31:24]};
endmodule

module eth_tx_fcs_ctrl #(
    parameter int unsigned MIN_FRAME  = 60,
    parameter int unsigned IFG_CYCLES = 12,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [9:0] pad_count
);
    localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    if (MIN_FRAME < 1 || MIN_FRAME > 1023) begin : g_min_frame_range
        $error("eth_tx_fcs_ctrl: MIN_FRAME must be in 1..1023");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
`ifdef ETH_TX_FCS_PAD_EN
        S_PAD,
`endif
        S_FCS,
        S_IFG
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_fcs_idx;
    logic [IFG_W-1:0]  r_ifg_cnt;
    logic [31:0]       w_crc;
    logic              w_crc_rst;
    logic              w_crc_valid;
    logic [7:0]        w_crc_data;
    logic [7:0]        w_fcs_byte;
    logic              w_data_acc;

    assign w_data_acc = (r_state == S_DATA) && s_valid && m_ready;

`ifdef ETH_TX_FCS_PAD_EN
    logic [9:0]  r_count;
    logic [9:0]  r_pad_pend;
    logic [9:0]  r_pad_count;
    logic [10:0] w_count_p1;
    logic        w_need_pad;
    logic        w_cnt_en;

    assign w_count_p1 = {1'b0, r_count} + 11'd1;
    assign w_need_pad = w_count_p1 < 11'(MIN_FRAME);
    assign w_cnt_en   = w_data_acc || ((r_state == S_PAD) && m_ready);
    assign pad_count  = r_pad_count;

    always_ff @(posedge clk) begin
        if (!rst_n || r_state == S_IDLE) begin
            r_count <= '0;
        end else if (w_cnt_en && r_count != '1) begin
            r_count <= r_count + 10'd1;
        end
    end

    // Pad length is fixed when s_last is accepted but only published with frame_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pad_pend  <= '0;
            r_pad_count <= '0;
        end else begin
            if (w_data_acc && s_last) begin
                r_pad_pend <= w_need_pad ? (10'(MIN_FRAME) - w_count_p1[9:0]) : '0;
            end
            if (frame_done) begin
                r_pad_count <= r_pad_pend;
            end
        end
    end
`else
    assign pad_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (s_valid) w_next_state = S_DATA;
            S_DATA: begin
                if (w_data_acc && s_last) begin
`ifdef ETH_TX_FCS_PAD_EN
                    w_next_state = w_need_pad ? S_PAD : S_FCS;
`else
                    w_next_state = S_FCS;
`endif
                end
            end
`ifdef ETH_TX_FCS_PAD_EN
            S_PAD: if (m_ready && w_count_p1 == 11'(MIN_FRAME)) w_next_state = S_FCS;
`endif
            S_FCS: begin
                if (m_ready && r_fcs_idx == 2'd3) begin
                    w_next_state = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
                end
            end
            S_IFG: if (r_ifg_cnt == IFG_W'(IFG_CYCLES - 1)) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (r_fcs_idx)
            2'd0: w_fcs_byte = w_crc[31:24];
            2'd1: w_fcs_byte = w_crc[23:16];
            2'd2: w_fcs_byte = w_crc[15:8];
            default: w_fcs_byte = w_crc[7:0];
        endcase
    end

    always_comb begin
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        frame_done  = 1'b0;
        w_crc_valid = 1'b0;
        unique case (r_state)
            S_DATA: begin
                s_ready     = m_ready;
                m_valid     = s_valid;
                m_data      = s_data;
                w_crc_valid = s_valid && m_ready;
            end
`ifdef ETH_TX_FCS_PAD_EN
            S_PAD: begin
                m_valid     = 1'b1;
                m_data      = PAD_BYTE;
                w_crc_valid = m_ready;
            end
`endif
            S_FCS: begin
                m_valid    = 1'b1;
                m_data     = w_fcs_byte;
                m_last     = (r_fcs_idx == 2'd3);
                frame_done = m_ready && (r_fcs_idx == 2'd3);
            end
            default: ;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign w_crc_rst  = !rst_n || (r_state == S_IDLE);
    assign w_crc_data = (r_state == S_DATA) ? s_data : PAD_BYTE;

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != S_FCS) begin
            r_fcs_idx <= '0;
        end else if (m_ready) begin
            r_fcs_idx <= r_fcs_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != S_IFG) begin
            r_ifg_cnt <= '0;
        end else begin
            r_ifg_cnt <= r_ifg_cnt + 1'b1;
        end
    end

    crc32 u_crc (
        .clk   (clk),
        .rst   (w_crc_rst),
        .valid (w_crc_valid),
        .data  (w_crc_data),
        .crc   (w_crc)
    );
endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Directed bench for eth_tx_fcs_ctrl (MIN_FRAME=60, IFG_CYCLES=12); expectations follow ETH_TX_FCS_PAD_EN.
module tb_eth_tx_fcs_ctrl;
    localparam int MIN_F = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       busy;
    logic       frame_done;
    logic [9:0] pad_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pay [0:127];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_pad;

    always #5 clk = ~clk;

    eth_tx_fcs_ctrl #(
        .MIN_FRAME  (MIN_F),
        .IFG_CYCLES (12),
        .PAD_BYTE   (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .pad_count  (pad_count)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference frame: payload, optional zero pad, then bitwise reflected CRC-32 sent LSB first.
    task automatic build_exp(input int len);
        logic [31:0] c;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
        exp_pad = 0;
`ifdef ETH_TX_FCS_PAD_EN
        while (exp_q.size() < MIN_F) begin
            exp_q.push_back(8'h00);
            exp_pad++;
        end
`endif
        c = 32'hFFFF_FFFF;
        foreach (exp_q[i]) begin
            c = c ^ {24'h0, exp_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    task automatic run_frame(input string name, input int len, input bit rnd, input int exp_lead);
        int idx = 0, lead = 0, done_cnt = 0;
        bit started = 0, fin = 0, mv_lead = 0, prev_stall = 0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        build_exp(len);
        got_q.delete();
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(posedge clk); #1;
            s_valid = (idx < len);
            s_data  = (idx < len) ? pay[idx] : 8'h00;
            s_last  = (idx == len - 1);
            m_ready = (rnd && started) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!started) begin
                if (s_ready) started = 1;
                else begin
                    lead++;
                    if (m_valid) mv_lead = 1;
                end
            end
            if (prev_stall)
                check_val({name, "_stall_hold"}, {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (s_valid && s_ready) idx++;
            if (frame_done) done_cnt++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                if (m_last) begin
                    fin = 1;
                    check_val({name, "_done_with_last"}, frame_done, 1);
                end
            end
        end
        check_val({name, "_finished"}, fin, 1);
        check_val({name, "_lead_bubbles"}, lead, exp_lead);
        check_val({name, "_mvalid_in_gap"}, mv_lead, 0);
        check_val({name, "_done_pulses"}, done_cnt, 1);
        check_val({name, "_out_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_val({name, "_pad_count"}, pad_count, exp_pad);
        check_val({name, "_busy_in_ifg"}, busy, 1);
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
        check_val("idle_busy", busy, 0);
    endtask

    task automatic load_123456789();
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    endtask

    // Hand-known FCS of "123456789" (CRC-32 0xCBF43926) when no pad is inserted.
    task automatic check_check_string(input string name);
`ifndef ETH_TX_FCS_PAD_EN
        logic [7:0] fcs [0:3];
        fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
        check_val({name, "_len13"}, got_q.size(), 13);
        for (int i = 0; i < 4 && 9 + i < got_q.size(); i++)
            check_val($sformatf("%s_fcs%0d", name, i), got_q[9 + i], fcs[i]);
`else
        check_val({name, "_len64"}, got_q.size(), 64);
`endif
    endtask

    task automatic load_hdr14();
        logic [7:0] h [0:13];
        h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
        for (int i = 0; i < 14; i++) pay[i] = h[i];
    endtask

    task automatic abort_frame(input int len, input int n_out);
        int idx = 0, cnt = 0;
        for (int cyc = 0; cyc < 500 && cnt < n_out; cyc++) begin
            @(posedge clk); #1;
            s_valid = (idx < len);
            s_data  = (idx < len) ? pay[idx] : 8'h00;
            s_last  = (idx == len - 1);
            m_ready = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            if (m_valid && m_ready) cnt++;
        end
        check_val("abort_reached", cnt, n_out);
        @(posedge clk); #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("abort_s_ready", s_ready, 0);
        check_val("abort_m_valid", m_valid, 0);
        check_val("abort_m_last", m_last, 0);
        check_val("abort_m_data", m_data, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_frame_done", frame_done, 0);
        check_val("abort_pad_count", pad_count, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_last", m_last, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_pad_count", pad_count, 0);
        rst_n = 1'b1;

        load_123456789();
        run_frame("chk9", 9, 1'b0, 1);
        check_check_string("chk9");
        idle_wait(16);

        load_hdr14();
        run_frame("hdr14", 14, 1'b0, 1);
`ifdef ETH_TX_FCS_PAD_EN
        check_val("hdr14_total", got_q.size(), 64);
`else
        check_val("hdr14_total", got_q.size(), 18);
`endif
        idle_wait(16);

        for (int i = 0; i < 100; i++) pay[i] = 8'(i * 7 + 3);
        run_frame("rnd100", 100, 1'b1, 1);
        idle_wait(16);

        // Second frame starts right after the first; one IFG cycle is spent checking pad_count.
        load_hdr14();
        run_frame("b2b_a", 14, 1'b0, 1);
        load_123456789();
        run_frame("b2b_b", 9, 1'b0, 12);
        check_check_string("b2b_b");
        idle_wait(16);

        load_hdr14();
        abort_frame(14, 16);
        load_123456789();
        run_frame("post_rst", 9, 1'b0, 1);
        check_check_string("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
